// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-side signal bundle for alu_arbiter.
// slave is the arbiter; master is the environment (requesters, response consumer, ALU).
interface alu_arbiter_if #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_REQ       = 2,
    parameter int ID_W          = 1
);
    logic [NUM_REQ-1:0]               req_valid_i;
    logic [NUM_REQ-1:0]               req_ready_o;
    logic [NUM_REQ*REGISTER_SIZE-1:0] req_data1_i;
    logic [NUM_REQ*REGISTER_SIZE-1:0] req_data2_i;
    logic [NUM_REQ*7-1:0]             req_opcode_i;
    logic [NUM_REQ*3-1:0]             req_func3_i;
    logic [NUM_REQ*7-1:0]             req_func7_i;

    logic [REGISTER_SIZE-1:0]         alu_data1_o;
    logic [REGISTER_SIZE-1:0]         alu_data2_o;
    logic [6:0]                       alu_opcode_o;
    logic [2:0]                       alu_func3_o;
    logic [6:0]                       alu_func7_o;
    logic [REGISTER_SIZE-1:0]         alu_result_i;
    logic                             alu_error_i;

    logic                             rsp_valid_o;
    logic                             rsp_ready_i;
    logic [ID_W-1:0]                  rsp_id_o;
    logic [REGISTER_SIZE-1:0]         rsp_result_o;
    logic                             rsp_error_o;

    modport master (
        output req_valid_i, req_data1_i, req_data2_i, req_opcode_i, req_func3_i, req_func7_i,
        input  req_ready_o,
        input  alu_data1_o, alu_data2_o, alu_opcode_o, alu_func3_o, alu_func7_o,
        output alu_result_i, alu_error_i,
        input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_error_o,
        output rsp_ready_i
    );

    modport slave (
        input  req_valid_i, req_data1_i, req_data2_i, req_opcode_i, req_func3_i, req_func7_i,
        output req_ready_o,
        output alu_data1_o, alu_data2_o, alu_opcode_o, alu_func3_o, alu_func7_o,
        input  alu_result_i, alu_error_i,
        output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_error_o,
        input  rsp_ready_i
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NUM_REQ requesters, one operation in flight.
// Define ALU_ARB_FIXED_PRIORITY_EN for strict lowest-index-first arbitration (default: round-robin).
module alu_arbiter #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_REQ       = 2,
    parameter int ID_W          = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [REGISTER_SIZE-1:0] op_data1_q, op_data1_d;
    logic [REGISTER_SIZE-1:0] op_data2_q, op_data2_d;
    logic [6:0]               op_opcode_q, op_opcode_d;
    logic [2:0]               op_func3_q, op_func3_d;
    logic [6:0]               op_func7_q, op_func7_d;
    logic [ID_W-1:0]          op_id_q, op_id_d;
    logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
    logic [REGISTER_SIZE-1:0] rsp_result_q, rsp_result_d;
    logic                     rsp_error_q, rsp_error_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
    logic [ID_W-1:0]          last_grant_q, last_grant_d;
`endif

    logic                     grant_found;
    logic [ID_W-1:0]          grant_idx;
    logic                     accept;
    logic [NUM_REQ-1:0]       req_ready;
    logic [REGISTER_SIZE-1:0] sel_data1, sel_data2;
    logic [6:0]               sel_opcode, sel_func7;
    logic [2:0]               sel_func3;

    logic [REGISTER_SIZE-1:0] data1_arr  [NUM_REQ];
    logic [REGISTER_SIZE-1:0] data2_arr  [NUM_REQ];
    logic [6:0]               opcode_arr [NUM_REQ];
    logic [2:0]               func3_arr  [NUM_REQ];
    logic [6:0]               func7_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data1_arr[g]  = bus.req_data1_i[g*REGISTER_SIZE +: REGISTER_SIZE];
        assign data2_arr[g]  = bus.req_data2_i[g*REGISTER_SIZE +: REGISTER_SIZE];
        assign opcode_arr[g] = bus.req_opcode_i[g*7 +: 7];
        assign func3_arr[g]  = bus.req_func3_i[g*3 +: 3];
        assign func7_arr[g]  = bus.req_func7_i[g*7 +: 7];
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && bus.req_valid_i[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
`else
        // Visit requesters in order last_grant+1, last_grant+2, ... wrapping at NUM_REQ.
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_found && bus.req_valid_i[j] &&
                    (j == ((int'(last_grant_q) + i) % NUM_REQ))) begin
                    grant_found = 1'b1;
                    grant_idx   = ID_W'(j);
                end
            end
        end
`endif
    end

    assign accept = (state_q == IDLE) && grant_found;

    always_comb begin
        sel_data1  = '0;
        sel_data2  = '0;
        sel_opcode = '0;
        sel_func3  = '0;
        sel_func7  = '0;
        req_ready  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == ID_W'(j)) begin
                sel_data1    = data1_arr[j];
                sel_data2    = data2_arr[j];
                sel_opcode   = opcode_arr[j];
                sel_func3    = func3_arr[j];
                sel_func7    = func7_arr[j];
                req_ready[j] = accept;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        op_data1_d   = op_data1_q;
        op_data2_d   = op_data2_q;
        op_opcode_d  = op_opcode_q;
        op_func3_d   = op_func3_q;
        op_func7_d   = op_func7_q;
        op_id_d      = op_id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_data1_d  = sel_data1;
                    op_data2_d  = sel_data2;
                    op_opcode_d = sel_opcode;
                    op_func3_d  = sel_func3;
                    op_func7_d  = sel_func7;
                    op_id_d     = grant_idx;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
                    last_grant_d = grant_idx;
`endif
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                // The ALU has had a full cycle on the op registers; sample its answer now.
                rsp_id_d     = op_id_q;
                rsp_result_d = bus.alu_result_i;
                rsp_error_d  = bus.alu_error_i;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            op_data1_q   <= '0;
            op_data2_q   <= '0;
            op_opcode_q  <= '0;
            op_func3_q   <= '0;
            op_func7_q   <= '0;
            op_id_q      <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q      <= state_d;
            op_data1_q   <= op_data1_d;
            op_data2_q   <= op_data2_d;
            op_opcode_q  <= op_opcode_d;
            op_func3_q   <= op_func3_d;
            op_func7_q   <= op_func7_d;
            op_id_q      <= op_id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.alu_data1_o  = op_data1_q;
    assign bus.alu_data2_o  = op_data2_q;
    assign bus.alu_opcode_o = op_opcode_q;
    assign bus.alu_func3_o  = op_func3_q;
    assign bus.alu_func7_o  = op_func7_q;
    assign bus.rsp_valid_o  = (state_q == RESP);
    assign bus.rsp_id_o     = rsp_id_q;
    assign bus.rsp_result_o = rsp_result_q;
    assign bus.rsp_error_o  = rsp_error_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven bench with a reference ALU, arbitration model and response scoreboard.
// Build with ALU_ARB_FIXED_PRIORITY_EN defined to check the fixed-priority grant order instead.
module tb_alu_arbiter;
    localparam int RS      = 32;
    localparam int NR      = 2;
    localparam int IW      = 1;
    localparam int NUM_VEC = 17;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum int {M_IDLE, M_EXEC, M_RESP} mstate_e;

    typedef struct {
        int          req;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] res;
        logic        err;
        int          phase;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;

    alu_arbiter_if #(.REGISTER_SIZE(RS), .NUM_REQ(NR), .ID_W(IW)) bus();

    alu_arbiter #(.REGISTER_SIZE(RS), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_fail   = 0;
    vec_t    tbl [NUM_VEC];
    vec_t    idle_v;
    vec_t    pend0[$];
    vec_t    pend1[$];
    vec_t    sb[$];
    int      glog[$];
    int      exp_q[$];
    bit      acc0 = 1'b0;
    bit      acc1 = 1'b0;
    mstate_e m_state = M_IDLE;
    logic [IW-1:0] m_last = IW'(NR - 1);
    int      cycle = 0;
    int      acc_cycle = 0;
    bit      first_resp = 1'b0;
    int      mon_w;
    logic [NR-1:0] mon_exp_rdy;

    // Reference ALU: R-type ADD/SUB/XOR/OR/AND; anything else reports an error with result 0.
    always_comb begin
        bus.alu_result_i = '0;
        bus.alu_error_i  = 1'b0;
        if (bus.alu_opcode_o == OP_R) begin
            case ({bus.alu_func7_o, bus.alu_func3_o})
                {7'h00, 3'b000}: bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
                {7'h20, 3'b000}: bus.alu_result_i = bus.alu_data1_o - bus.alu_data2_o;
                {7'h00, 3'b100}: bus.alu_result_i = bus.alu_data1_o ^ bus.alu_data2_o;
                {7'h00, 3'b110}: bus.alu_result_i = bus.alu_data1_o | bus.alu_data2_o;
                {7'h00, 3'b111}: bus.alu_result_i = bus.alu_data1_o & bus.alu_data2_o;
                default:         bus.alu_error_i  = 1'b1;
            endcase
        end else begin
            bus.alu_error_i = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input bit vld, input vec_t v);
        if (k == 0) begin
            bus.req_valid_i[0]    = vld;
            bus.req_data1_i[31:0] = v.d1;
            bus.req_data2_i[31:0] = v.d2;
            bus.req_opcode_i[6:0] = v.op;
            bus.req_func3_i[2:0]  = v.f3;
            bus.req_func7_i[6:0]  = v.f7;
        end else begin
            bus.req_valid_i[1]     = vld;
            bus.req_data1_i[63:32] = v.d1;
            bus.req_data2_i[63:32] = v.d2;
            bus.req_opcode_i[13:7] = v.op;
            bus.req_func3_i[5:3]   = v.f3;
            bus.req_func7_i[13:7]  = v.f7;
        end
    endtask

    function automatic int predictWinner(input logic [NR-1:0] v, input int last);
        logic [2*NR-1:0] dbl;
        logic [NR-1:0]   rot;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        dbl = '0;
        rot = v;
        for (int k = 0; k < NR; k++) if (rot[k]) return k;
        return (last < 0) ? -2 : -1;
`else
        dbl = {v, v};
        rot = NR'(dbl >> ((last + 1) % NR));
        for (int k = 0; k < NR; k++) if (rot[k]) return (last + 1 + k) % NR;
        return -1;
`endif
    endfunction

    task automatic loadPhase(input int p);
        for (int i = 0; i < NUM_VEC; i++) begin
            if (tbl[i].phase == p) begin
                if (tbl[i].req == 0) pend0.push_back(tbl[i]);
                else                 pend1.push_back(tbl[i]);
            end
        end
    endtask

    task automatic waitState(input mstate_e s, input int budget);
        int n = 0;
        while (m_state != s && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_state != s) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL wait_state: actual %0d, expected %0d", m_state, s);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0 || m_state != M_IDLE) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0 || m_state != M_IDLE) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: actual %0d ops outstanding, expected 0", sb.size() + pend0.size() + pend1.size());
        end
    endtask

    task automatic checkGrantOrder(input string name);
        checkOutput({name, "_count"}, 64'(glog.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < glog.size(); i++)
            checkOutput(name, 64'(glog[i]), 64'(exp_q[i]));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"},  64'(bus.req_ready_o),  64'd0);
        checkOutput({tag, "_rsp_valid"},  64'(bus.rsp_valid_o),  64'd0);
        checkOutput({tag, "_rsp_id"},     64'(bus.rsp_id_o),     64'd0);
        checkOutput({tag, "_rsp_result"}, 64'(bus.rsp_result_o), 64'd0);
        checkOutput({tag, "_rsp_error"},  64'(bus.rsp_error_o),  64'd0);
        checkOutput({tag, "_alu_data1"},  64'(bus.alu_data1_o),  64'd0);
        checkOutput({tag, "_alu_data2"},  64'(bus.alu_data2_o),  64'd0);
        checkOutput({tag, "_alu_opcode"}, 64'(bus.alu_opcode_o), 64'd0);
        checkOutput({tag, "_alu_func3"},  64'(bus.alu_func3_o),  64'd0);
        checkOutput({tag, "_alu_func7"},  64'(bus.alu_func7_o),  64'd0);
    endtask

    // Requester driver: each requester presents the head of its queue until the monitor sees it accepted.
    initial begin
        idle_v = '{0, 32'd0, 32'd0, 7'd0, 3'd0, 7'd0, 32'd0, 1'b0, 0};
        applyStimulus(0, 1'b0, idle_v);
        applyStimulus(1, 1'b0, idle_v);
        forever begin
            @(posedge clk); #2;
            if (acc0) begin
                acc0 = 1'b0;
                if (pend0.size() > 0) pend0.delete(0);
            end
            if (acc1) begin
                acc1 = 1'b0;
                if (pend1.size() > 0) pend1.delete(0);
            end
            if (pend0.size() > 0) applyStimulus(0, 1'b1, pend0[0]);
            else                  applyStimulus(0, 1'b0, idle_v);
            if (pend1.size() > 0) applyStimulus(1, 1'b1, pend1[0]);
            else                  applyStimulus(1, 1'b0, idle_v);
        end
    end

    // Monitor: tracks the expected FSM phase, predicts grants, pushes and pops the scoreboard.
    always @(negedge clk) begin
        cycle++;
        if (rst_i) begin
            m_state = M_IDLE;
            m_last  = IW'(NR - 1);
            sb.delete();
        end else begin
            case (m_state)
                M_IDLE: begin
                    mon_w       = predictWinner(bus.req_valid_i, int'(m_last));
                    mon_exp_rdy = (mon_w >= 0) ? (NR'(1) << mon_w) : '0;
                    checkOutput("req_ready_idle", 64'(bus.req_ready_o), 64'(mon_exp_rdy));
                    checkOutput("rsp_valid_idle", 64'(bus.rsp_valid_o), 64'd0);
                    if (mon_w >= 0) begin
                        if (mon_w == 0 && pend0.size() > 0) sb.push_back(pend0[0]);
                        if (mon_w == 1 && pend1.size() > 0) sb.push_back(pend1[0]);
                        if (mon_w == 0) acc0 = 1'b1;
                        else            acc1 = 1'b1;
                        m_last     = IW'(mon_w);
                        acc_cycle  = cycle;
                        first_resp = 1'b1;
                        m_state    = M_EXEC;
                    end
                end
                M_EXEC: begin
                    checkOutput("req_ready_exec", 64'(bus.req_ready_o), 64'd0);
                    checkOutput("rsp_valid_exec", 64'(bus.rsp_valid_o), 64'd0);
                    if (sb.size() > 0) begin
                        checkOutput("alu_data1",  64'(bus.alu_data1_o),  64'(sb[0].d1));
                        checkOutput("alu_data2",  64'(bus.alu_data2_o),  64'(sb[0].d2));
                        checkOutput("alu_opcode", 64'(bus.alu_opcode_o), 64'(sb[0].op));
                        checkOutput("alu_func3",  64'(bus.alu_func3_o),  64'(sb[0].f3));
                        checkOutput("alu_func7",  64'(bus.alu_func7_o),  64'(sb[0].f7));
                    end
                    m_state = M_RESP;
                end
                M_RESP: begin
                    checkOutput("rsp_valid_resp", 64'(bus.rsp_valid_o), 64'd1);
                    checkOutput("req_ready_resp", 64'(bus.req_ready_o), 64'd0);
                    if (first_resp) begin
                        checkOutput("latency", 64'(cycle - acc_cycle), 64'd2);
                        first_resp = 1'b0;
                    end
                    if (sb.size() > 0) begin
                        checkOutput("rsp_id",     64'(bus.rsp_id_o),     64'(sb[0].req));
                        checkOutput("rsp_result", 64'(bus.rsp_result_o), 64'(sb[0].res));
                        checkOutput("rsp_error",  64'(bus.rsp_error_o),  64'(sb[0].err));
                    end else begin
                        checkOutput("sb_nonempty", 64'd0, 64'd1);
                    end
                    if (bus.rsp_ready_i) begin
                        glog.push_back(int'(bus.rsp_id_o));
                        if (sb.size() > 0) sb.delete(0);
                        m_state = M_IDLE;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    initial begin
        #100000;
        $display("[TB] simulation watchdog expired after %0d checks", n_checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //            req  d1            d2            op    f3      f7     res           err  phase
        tbl[0]  = '{0, 32'd5,        32'd3,        OP_R, 3'b000, 7'h00, 32'd8,        1'b0, 1};
        tbl[1]  = '{1, 32'd7,        32'd9,        OP_I, 3'b000, 7'h00, 32'd0,        1'b1, 2};
        tbl[2]  = '{0, 32'd100,      32'd23,       OP_R, 3'b000, 7'h00, 32'd123,      1'b0, 3};
        tbl[3]  = '{0, 32'd3,        32'd10,       OP_R, 3'b000, 7'h20, 32'hFFFFFFF9, 1'b0, 3};
        tbl[4]  = '{1, 32'h0000F0F0, 32'h0000FF00, OP_R, 3'b111, 7'h00, 32'h0000F000, 1'b0, 3};
        tbl[5]  = '{1, 32'h0000AAAA, 32'h00005555, OP_R, 3'b100, 7'h00, 32'h0000FFFF, 1'b0, 3};
        tbl[6]  = '{0, 32'h0000000F, 32'h000000F0, OP_R, 3'b110, 7'h00, 32'h000000FF, 1'b0, 4};
        tbl[7]  = '{1, 32'hFFFF0000, 32'h12345678, OP_R, 3'b111, 7'h00, 32'h12340000, 1'b0, 4};
        tbl[8]  = '{0, 32'd1,        32'd1,        OP_R, 3'b000, 7'h00, 32'd2,        1'b0, 5};
        tbl[9]  = '{0, 32'h7FFFFFFF, 32'd1,        OP_R, 3'b000, 7'h00, 32'h80000000, 1'b0, 6};
        tbl[10] = '{1, 32'hFFFFFFFF, 32'h0F0F0F0F, OP_R, 3'b100, 7'h00, 32'hF0F0F0F0, 1'b0, 6};
        tbl[11] = '{0, 32'd1,        32'd2,        OP_R, 3'b000, 7'h00, 32'd3,        1'b0, 7};
        tbl[12] = '{0, 32'd4,        32'd4,        OP_R, 3'b000, 7'h00, 32'd8,        1'b0, 7};
        tbl[13] = '{0, 32'd20,       32'd22,       OP_R, 3'b000, 7'h00, 32'd42,       1'b0, 7};
        tbl[14] = '{1, 32'd3,        32'd6,        OP_R, 3'b111, 7'h00, 32'd2,        1'b0, 7};
        tbl[15] = '{1, 32'd8,        32'd1,        OP_R, 3'b110, 7'h00, 32'd9,        1'b0, 7};
        tbl[16] = '{1, 32'd5,        32'd5,        OP_R, 3'b100, 7'h00, 32'd0,        1'b0, 7};

        rst_i           = 1'b1;
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Single ADD from req0, then an illegal opcode from req1 (moves the pointer to 1).
        for (int p = 1; p <= 3; p++) begin
            glog.delete();
            loadPhase(p);
            waitDrain(100);
            if (p == 1) exp_q = '{0};
            if (p == 2) exp_q = '{1};
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            if (p == 3) exp_q = '{0, 0, 1, 1};
`else
            if (p == 3) exp_q = '{0, 1, 0, 1};
`endif
            checkGrantOrder($sformatf("grant_order_p%0d", p));
        end

        // Response back-pressure: hold rsp_ready low for 5 cycles with req1 waiting.
        glog.delete();
        bus.rsp_ready_i = 1'b0;
        loadPhase(4);
        waitState(M_RESP, 20);
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus.rsp_ready_i = 1'b1;
        waitDrain(100);
        exp_q = '{0, 1};
        checkGrantOrder("grant_order_stall");

        // Reset while an op is executing: it must vanish and the pointer must restart at req0.
        glog.delete();
        loadPhase(5);
        waitState(M_EXEC, 20);
        rst_i = 1'b1;
        pend0.delete();
        pend1.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        checkAllZero("mid_exec_reset");
        @(posedge clk); #1;
        loadPhase(6);
        waitDrain(100);
        exp_q = '{0, 1};
        checkGrantOrder("grant_order_after_reset");

        // Both requesters busy for three ops each.
        glog.delete();
        loadPhase(7);
        waitDrain(200);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        exp_q = '{0, 0, 0, 1, 1, 1};
`else
        exp_q = '{0, 1, 0, 1, 0, 1};
`endif
        checkGrantOrder("grant_order_contention");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
